// File: rtl/mod997_pkg.sv
// Shared constants, state encoding and result payload for the mod-997
// residue accumulator and its reduce-then-add datapath.
package mod997_pkg;

  localparam int unsigned MOD        = 997;
  localparam int unsigned RW         = 10;
  localparam int unsigned NUM_CHUNKS = 67;
  localparam int unsigned CW         = 7;
  // One guard bit so acc + r (both < MOD) never overflows before reduction.
  localparam int unsigned SW         = RW + 1;

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } state_e;

  // Registered end-of-frame result; count width is fixed at CW.
  typedef struct packed {
    logic [RW-1:0] residue;
    logic [CW-1:0] count;
    logic          err_range;
    logic          err_len;
  } result_t;

  // Single conditional subtract: any RW-bit value is below 2*MOD.
  function automatic logic [RW-1:0] reduce_once(input logic [RW-1:0] x);
    return (x >= RW'(MOD)) ? RW'(x - RW'(MOD)) : x;
  endfunction

endpackage

// File: rtl/mod997_residue_accum_add.sv
// Combinational modular adder: range-reduces b, adds to a (already < MOD),
// then folds the sum back into 0..MOD-1.
//   a     : running residue, assumed < MOD
//   b     : incoming partial residue, any RW-bit value
//   sum   : (a + b) mod MOD
//   b_oor : b was >= MOD before reduction
module mod997_add
  import mod997_pkg::*;
(
  input  logic [RW-1:0] a,
  input  logic [RW-1:0] b,
  output logic [RW-1:0] sum,
  output logic          b_oor
);

  logic [RW-1:0] b_red;
  logic [SW-1:0] raw;

  // Reduce the operand first so the add stays within SW bits.
  always_comb begin
    b_oor = (b >= RW'(MOD));
    b_red = reduce_once(b);
    raw   = SW'(a) + SW'(b_red);
    sum   = (raw >= SW'(MOD)) ? RW'(raw - SW'(MOD)) : raw[RW-1:0];
  end

endmodule

// File: rtl/mod997_residue_accum.sv
// Frame accumulator for per-chunk mod-997 partial residues. Beats arrive on
// a valid/ready stream; each frame's sum mod 997, beat count and error flags
// are presented on a registered output handshake.
//   clk, rst          : rising-edge clock, async active-high reset
//   in_valid/in_ready : input beat handshake
//   in_residue        : partial residue, nominally < MOD
//   in_last           : final beat of the frame
//   out_valid/out_ready : result handshake
//   out_residue       : frame sum mod MOD
//   out_count         : beats accepted in the frame
//   out_err_range     : some beat in the frame was >= MOD
//   out_err_len       : frame length differed from N_CHUNKS
module mod997_residue_accum
  import mod997_pkg::*;
#(
  parameter int unsigned N_CHUNKS = NUM_CHUNKS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [RW-1:0] in_residue,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [RW-1:0] out_residue,
  output logic [CW-1:0] out_count,
  output logic          out_err_range,
  output logic          out_err_len
);

  state_e        state;
  logic [RW-1:0] acc;
  logic [CW-1:0] count;
  logic          range_sticky;
  result_t       result;

  logic [RW-1:0] sum;
  logic          b_oor;
  logic          accept;
  logic [CW-1:0] count_next;
  logic          count_hit;
  logic          frame_end;
  logic          range_next;

  mod997_add u_add (
    .a     (acc),
    .b     (in_residue),
    .sum   (sum),
    .b_oor (b_oor)
  );

  // Handshake flags decode straight from state; no input-to-output path.
  assign in_ready  = (state == ACC);
  assign out_valid = (state == DONE);

  // Frame terminates on in_last or when the expected length is reached,
  // so the counter can never wrap.
  always_comb begin
    accept     = in_valid && (state == ACC);
    count_next = count + CW'(1);
    count_hit  = (count_next == CW'(N_CHUNKS));
    frame_end  = accept && (in_last || count_hit);
    range_next = range_sticky || b_oor;
  end

  // State, accumulator and registered result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ACC;
      acc          <= '0;
      count        <= '0;
      range_sticky <= 1'b0;
      result       <= '0;
    end else begin
      case (state)
        ACC: begin
          if (accept) begin
            acc          <= sum;
            count        <= count_next;
            range_sticky <= range_next;
          end
          if (frame_end) begin
            result.residue   <= sum;
            result.count     <= count_next;
            result.err_range <= range_next;
            result.err_len   <= !(in_last && count_hit);
            state            <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            acc          <= '0;
            count        <= '0;
            range_sticky <= 1'b0;
            state        <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

  assign out_residue   = result.residue;
  assign out_count     = result.count;
  assign out_err_range = result.err_range;
  assign out_err_len   = result.err_len;

endmodule

// File: tb/tb_mod997_residue_accum.sv
// Bench for mod997_residue_accum: a 3-chunk instance and a default 67-chunk
// instance share one stimulus path selected by sel.
module tb_mod997_residue_accum;

  logic       clk = 1'b0;
  logic       rst;
  logic       sel;            // 0: 3-chunk instance, 1: 67-chunk instance
  logic       v;
  logic [9:0] res;
  logic       last;
  logic       ordy;

  logic       v3, v67, ordy3, ordy67;
  logic       rdy3, rdy67, ov3, ov67, er3, er67, el3, el67;
  logic [9:0] or3, or67;
  logic [6:0] oc3, oc67;

  logic       obs_in_ready, obs_out_valid, obs_err_range, obs_err_len;
  logic [9:0] obs_res;
  logic [6:0] obs_cnt;

  int checks = 0;
  int fails  = 0;
  int vals[80];
  int e_end, e_res, e_cnt, e_rng, e_len;

  always #5 clk = ~clk;

  assign v3     = v & ~sel;
  assign v67    = v & sel;
  assign ordy3  = ordy & ~sel;
  assign ordy67 = ordy & sel;

  assign obs_in_ready  = sel ? rdy67 : rdy3;
  assign obs_out_valid = sel ? ov67 : ov3;
  assign obs_res       = sel ? or67 : or3;
  assign obs_cnt       = sel ? oc67 : oc3;
  assign obs_err_range = sel ? er67 : er3;
  assign obs_err_len   = sel ? el67 : el3;

  mod997_residue_accum #(.N_CHUNKS(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(v3), .in_ready(rdy3), .in_residue(res),
    .in_last(last), .out_valid(ov3), .out_ready(ordy3), .out_residue(or3),
    .out_count(oc3), .out_err_range(er3), .out_err_len(el3)
  );

  mod997_residue_accum dut67 (
    .clk(clk), .rst(rst), .in_valid(v67), .in_ready(rdy67), .in_residue(res),
    .in_last(last), .out_valid(ov67), .out_ready(ordy67), .out_residue(or67),
    .out_count(oc67), .out_err_range(er67), .out_err_len(el67)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: frame result straight from the arithmetic definition.
  task automatic model(input int n_ch, input int last_idx);
    int sum = 0;
    e_end = (last_idx >= 0 && last_idx < n_ch) ? last_idx : n_ch - 1;
    e_rng = 0;
    for (int k = 0; k <= e_end; k++) begin
      sum += vals[k];
      if (vals[k] >= 997) e_rng = 1;
    end
    e_res = sum % 997;
    e_cnt = e_end + 1;
    e_len = (last_idx == e_end && e_cnt == n_ch) ? 0 : 1;
  endtask

  // Drives beats from vals[] until n_beats are accepted; starts and ends on a negedge.
  task automatic drive(input int n_beats, input int last_idx, input bit gaps);
    int  i = 0;
    int  guard = 0;
    bit  rdy;
    while (i < n_beats && guard < 3000) begin
      guard++;
      v    = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      res  = 10'(vals[i]);
      last = (i == last_idx);
      rdy  = obs_in_ready;
      @(negedge clk);
      if (v && rdy) i++;
    end
    v    = 1'b0;
    last = 1'b0;
    if (guard >= 3000) chk("beat_timeout", i, n_beats);
  endtask

  task automatic frame(input int n_ch, input int last_idx, input bit gaps);
    model(n_ch, last_idx);
    chk("ovalid_before_frame", obs_out_valid, 0);
    drive(e_end + 1, last_idx, gaps);
    chk("ovalid_latency", obs_out_valid, 1);
    chk("in_ready_done", obs_in_ready, 0);
    chk("out_residue", obs_res, e_res);
    chk("out_count", obs_cnt, e_cnt);
    chk("out_err_range", obs_err_range, e_rng);
    chk("out_err_len", obs_err_len, e_len);
  endtask

  // Holds the result under backpressure with in_valid asserted, then releases.
  task automatic drain(input int hold);
    for (int k = 0; k < hold; k++) begin
      v    = 1'b1;
      res  = 10'($urandom_range(0, 1023));
      ordy = 1'b0;
      @(negedge clk);
      chk("hold_ovalid", obs_out_valid, 1);
      chk("hold_in_ready", obs_in_ready, 0);
      chk("hold_residue", obs_res, e_res);
      chk("hold_count", obs_cnt, e_cnt);
    end
    v    = 1'b0;
    ordy = 1'b1;
    @(negedge clk);
    ordy = 1'b0;
    chk("release_ovalid", obs_out_valid, 0);
    chk("release_in_ready", obs_in_ready, 1);
  endtask

  task automatic check_reset_vals();
    chk("rst_in_ready", obs_in_ready, 1);
    chk("rst_out_valid", obs_out_valid, 0);
    chk("rst_out_residue", obs_res, 0);
    chk("rst_out_count", obs_cnt, 0);
    chk("rst_err_range", obs_err_range, 0);
    chk("rst_err_len", obs_err_len, 0);
  endtask

  task automatic reset_pulse();
    #2 rst = 1'b1;
    #1;
    check_reset_vals();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; v = 1'b0; res = '0; last = 1'b0; ordy = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals();
    sel = 1'b1;
    #1;
    check_reset_vals();
    @(negedge clk);
    rst = 1'b0;
    sel = 1'b0;

    // 3-chunk: 500, 500, 996 with last on the third beat.
    vals[0] = 500; vals[1] = 500; vals[2] = 996;
    frame(3, 2, 1'b0);
    chk("t1_residue", obs_res, 2);
    drain(0);

    // 67 beats of 996 with last on beat 67.
    sel = 1'b1;
    for (int k = 0; k < 67; k++) vals[k] = 996;
    frame(67, 66, 1'b0);
    chk("t2_residue", obs_res, 930);
    drain(1);

    // Out-of-range beat then short frame.
    vals[0] = 1000; vals[1] = 5;
    frame(67, 1, 1'b0);
    chk("t3_residue", obs_res, 8);
    drain(0);

    // 67 beats of 1, in_last never asserted: forced end, beat 68 held off.
    for (int k = 0; k < 80; k++) vals[k] = 1;
    frame(67, -1, 1'b0);
    chk("t4_residue", obs_res, 67);
    drain(5);

    // Next frame must start from zero after the stalled handshake.
    vals[0] = 10; vals[1] = 20;
    frame(67, 1, 1'b0);
    chk("t5_residue", obs_res, 30);
    drain(2);

    // Reset mid-frame on the 67-chunk instance, then a fresh 3-beat frame.
    for (int k = 0; k < 10; k++) vals[k] = 7;
    drive(10, -1, 1'b0);
    reset_pulse();
    vals[0] = 4; vals[1] = 4; vals[2] = 4;
    frame(67, 2, 1'b0);
    chk("t6_residue", obs_res, 12);
    drain(0);

    // Same on the 3-chunk instance.
    sel = 1'b0;
    vals[0] = 9; vals[1] = 9;
    drive(2, -1, 1'b0);
    reset_pulse();
    vals[0] = 4; vals[1] = 4; vals[2] = 4;
    frame(3, 2, 1'b0);
    chk("t7_residue", obs_res, 12);
    chk("t7_err_len", obs_err_len, 0);
    drain(1);

    // Random frames on both instances with input gaps and output stalls.
    for (int f = 0; f < 16; f++) begin
      int n_ch, len, li;
      sel  = f[0];
      n_ch = sel ? 67 : 3;
      len  = $urandom_range(1, n_ch + 4);
      li   = (len <= n_ch && $urandom_range(0, 3) != 0) ? len - 1 : -1;
      for (int k = 0; k < 80; k++) vals[k] = $urandom_range(0, 1023);
      frame(n_ch, li, 1'b1);
      drain($urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
